selector_accum: RTL and testbench
=================================

Name: selector_accum

Overview:
- Parametrised successor to the per-core bipolar selector.
- Each cycle it maps NUM_CORES core result/enable bit pairs to signed {-1,0,+1} selections.
- It accumulates those selections per channel in saturating counters over a bundle of updates.
- On finish it emits one majority bit per channel through a valid/ready handshake.
- Sits between the core array and the result write-back path. It replaces the external adder tree that sums sel_bit.

Parameters:
- NUM_CORES, 32, number of channels (one per core).
- ACC_WIDTH, 8, signed accumulator width per channel; minimum 2.
- CNT_WIDTH, 16, width of the update counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- update  in  1  sample core bits this cycle; accepted only when in_ready=1.
- core_result_bits  in  NUM_CORES  per-core result bit.
- core_enable_bits  in  NUM_CORES  per-core enable bit; 1 forces selection 0.
- finish  in  1  close the current bundle; accepted only when in_ready=1.
- clear  in  1  abort and zero all accumulators; accepted in any state.
- tie_bits  in  NUM_CORES  output bit used where an accumulator equals 0.
- in_ready  out  1  1 in state ACCUM.
- sel_bits  out  2*NUM_CORES  registered per-channel selection, 2-bit signed each; channel i occupies [2i+1:2i].
- out_bits  out  NUM_CORES  majority result per channel.
- out_valid  out  1  out_bits valid; held until out_ready.
- out_ready  in  1  downstream accepts out_bits.
- sat_flag  out  1  sticky; some channel clamped during the current bundle.
- update_count  out  CNT_WIDTH  updates accepted in the current bundle; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): state ACCUM.
  - All accumulators 0; sel_bits all 0.
  - out_bits 0, out_valid 0, sat_flag 0, update_count 0.
  - The 2-bit selection is explicitly signed, which avoids implicit sign extension of 1-bit literals.
- Selection stage. Per channel, registered on an accepted update; on any other cycle sel_bits is driven to 0.
  - enable=1 gives 0.
  - Otherwise result=0 gives +1.
  - Otherwise result=1 gives -1.
- Accumulate stage, one cycle after the selection stage:
  - acc_i <= sat(acc_i + sel_i).
  - Clamp range is symmetric, ±(2^(ACC_WIDTH-1)-1).
  - A clamp event sets sat_flag.
- Latency: update at edge t, sel_bits visible after t, acc includes it after edge t+1.
- FSM states: ACCUM, DRAIN, HOLD.
- ACCUM:
  - update increments update_count.
  - finish moves to DRAIN.
  - update and finish together: the update is accepted and included in the bundle.
- DRAIN (one cycle): the last selection lands in acc.
  - Next edge registers out_bits.
  - Per channel: acc<0 gives 1, acc>0 gives 0, acc==0 gives tie_bits[i]. tie_bits is sampled on this edge.
  - out_valid set to 1; go to HOLD.
  - Net effect: out_valid rises at the second edge after finish is sampled.
- HOLD:
  - out_bits and out_valid are stable and in_ready=0.
  - update and finish are ignored (not counted).
  - out_valid & out_ready: at that edge accumulators, update_count and sat_flag are zeroed, out_valid goes 0, state goes to ACCUM.
- clear: highest priority in all states.
  - Zeroes accumulators, sel_bits, update_count, sat_flag and out_valid; state goes to ACCUM.
  - An update or finish in the same cycle is dropped.
  - A pending in-flight selection is discarded.
- Empty bundle (finish with zero updates): every out_bits[i] = tie_bits[i].
- out_ready while out_valid=0: ignored.

Decomposition:
- Package selector_pkg:
  - typedef sel_t (logic signed [1:0]).
  - constants SEL_POS=+1, SEL_NEG=-1, SEL_ZERO=0.
  - state enum {ACCUM, DRAIN, HOLD}.
  - saturating-add function sat_add(acc, sel, width).
- One sub-module is natural: selector_lane, a per-channel selection register plus saturating accumulator plus sign decode, generated NUM_CORES times.
- The FSM and counters live in the top level.

Test Plan:
- NUM_CORES=4: 3 updates with result=0000, enable=0000, then finish -> acc=+3 each, out_bits=0000, out_valid at second edge after finish, update_count=3.
- Mixed lanes over 2 updates:
  - Update 1: result=1010, enable=0100. Update 2: result=1000, enable=0000.
  - Accumulators: lane3=-2, lane2=+1, lane1=0 (-1,+1), lane0=+2.
  - With tie_bits=0010, out_bits=1010.
- ACC_WIDTH=3: 5 consecutive -1 updates on lane0 -> acc clamps at -3, sat_flag=1, out_bits[0]=1.
  - Handshake clears sat_flag and update_count to 0.
- HOLD backpressure:
  - out_ready=0 for 10 cycles while update pulses -> out_bits stable, in_ready=0, update_count unchanged.
  - out_ready=1 -> returns to ACCUM with acc=0.
- clear in DRAIN together with update -> out_valid never rises, update_count=0, next bundle starts from acc=0.
- Async reset: rst_n low mid-HOLD, not aligned to clk -> out_valid=0, sel_bits=0, in_ready=1 immediately.
  - First bundle after release is correct.

Source files
------------

// File: rtl/selector_pkg.sv
// Shared types and helpers for the bipolar selector accumulator: selection
// encoding, control states and the symmetric saturating add.
package selector_pkg;

  typedef logic signed [1:0] sel_t;

  localparam sel_t SEL_POS  = 2'sb01;
  localparam sel_t SEL_NEG  = 2'sb11;
  localparam sel_t SEL_ZERO = 2'sb00;

  // Internal arithmetic width; wide enough for any sensible ACC_WIDTH.
  localparam int SUM_W = 32;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  function automatic sel_t to_sel(input logic result, input logic enable);
    if (enable)      return SEL_ZERO;
    else if (result) return SEL_NEG;
    else             return SEL_POS;
  endfunction

  // Symmetric clamp to +/-(2^(width-1)-1); the most negative code is never produced.
  function automatic logic signed [SUM_W-1:0] sat_add(
    input logic signed [SUM_W-1:0] acc,
    input sel_t                    sel,
    input int                      width
  );
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] lim;
    logic signed [SUM_W-1:0] sum;
    one = 1;
    lim = (one <<< (width - 1)) - one;
    sum = acc + sel;
    if (sum > lim)       return lim;
    else if (sum < -lim) return -lim;
    else                 return sum;
  endfunction

endpackage

// File: rtl/selector_lane.sv
// One channel: registered selection, saturating accumulator and the
// sign decode of the value the accumulator is about to take.
module selector_lane
  import selector_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic clear_i,
  input  logic result_i,
  input  logic enable_i,
  input  logic tie_i,
  output sel_t sel_o,
  output logic clamp_o,
  output logic major_o
);

  sel_t                        sel_q, sel_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0]     raw_sum;
  logic signed [SUM_W-1:0]     sat_sum;

  always_comb begin
    raw_sum = SUM_W'(acc_q) + SUM_W'(sel_q);
    sat_sum = sat_add(SUM_W'(acc_q), sel_q, ACC_WIDTH);
    clamp_o = (raw_sum != sat_sum);
    sel_d   = sample_i ? to_sel(result_i, enable_i) : SEL_ZERO;
    acc_d   = clear_i ? '0 : sat_sum[ACC_WIDTH-1:0];
    // Decode the post-add value so the bundle's final selection is counted.
    if (sat_sum < 0)       major_o = 1'b1;
    else if (sat_sum == 0) major_o = tie_i;
    else                   major_o = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_ZERO;
      acc_q <= '0;
    end else begin
      sel_q <= sel_d;
      acc_q <= acc_d;
    end
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/selector_accum.sv
// Bundle controller: samples per-core selections, accumulates them per
// channel and presents one majority bit per channel over valid/ready.
module selector_accum
  import selector_pkg::*;
#(
  parameter int NUM_CORES = 32,
  parameter int ACC_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   update,
  input  logic [NUM_CORES-1:0]   core_result_bits,
  input  logic [NUM_CORES-1:0]   core_enable_bits,
  input  logic                   finish,
  input  logic                   clear,
  input  logic [NUM_CORES-1:0]   tie_bits,
  output logic                   in_ready,
  output logic [2*NUM_CORES-1:0] sel_bits,
  output logic [NUM_CORES-1:0]   out_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag,
  output logic [CNT_WIDTH-1:0]   update_count
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic [NUM_CORES-1:0]   obits_q, obits_d;
  logic [NUM_CORES-1:0]   clamp, major;
  logic                   accept_upd, accept_fin, handshake, lane_clear;

  assign in_ready   = (state_q == ACCUM);
  assign accept_upd = update & in_ready & ~clear;
  assign accept_fin = finish & in_ready & ~clear;
  assign handshake  = valid_q & out_ready;
  assign lane_clear = clear | handshake;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    sel_t lane_sel;
    selector_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_i (accept_upd),
      .clear_i  (lane_clear),
      .result_i (core_result_bits[i]),
      .enable_i (core_enable_bits[i]),
      .tie_i    (tie_bits[i]),
      .sel_o    (lane_sel),
      .clamp_o  (clamp[i]),
      .major_o  (major[i])
    );
    assign sel_bits[2*i +: 2] = lane_sel;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q | (|clamp);
    valid_d = valid_q;
    obits_d = obits_q;
    unique case (state_q)
      ACCUM: begin
        if (accept_upd && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (accept_fin) state_d = DRAIN;
      end
      DRAIN: begin
        obits_d = major;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    // Abort wins over everything, including an in-flight selection.
    if (clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
      sat_d   = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      obits_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      obits_q <= obits_d;
    end
  end

  assign out_bits     = obits_q;
  assign out_valid    = valid_q;
  assign sat_flag     = sat_q;
  assign update_count = cnt_q;

endmodule

// File: tb/tb_selector_accum.sv
// Directed bench: expected majority words are queued at finish and a
// negedge monitor compares them when the output handshake occurs.
module tb_selector_accum;

  localparam int NC = 4;
  localparam int AW = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            update = 1'b0;
  logic [NC-1:0]   res = '0;
  logic [NC-1:0]   en = '0;
  logic            finish = 1'b0;
  logic            clear = 1'b0;
  logic [NC-1:0]   tie = '0;
  logic            in_ready;
  logic [2*NC-1:0] sel_bits;
  logic [NC-1:0]   out_bits;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            sat_flag;
  logic [CW-1:0]   update_count;

  logic [NC-1:0]   exp_q[$];
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  selector_accum #(.NUM_CORES(NC), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .update           (update),
    .core_result_bits (res),
    .core_enable_bits (en),
    .finish           (finish),
    .clear            (clear),
    .tie_bits         (tie),
    .in_ready         (in_ready),
    .sel_bits         (sel_bits),
    .out_bits         (out_bits),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sat_flag         (sat_flag),
    .update_count     (update_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a valid & ready seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_bits_unexpected: got %0h with no expected entry", out_bits);
      end else begin
        check("out_bits", out_bits, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [NC-1:0] r, input logic [NC-1:0] e);
    update = 1'b1; res = r; en = e;
    cyc();
    update = 1'b0;
  endtask

  // Finish a bundle (optionally with a same-cycle update); tie is only
  // valid during the DRAIN cycle and inverted afterwards.
  task automatic fin(input logic with_upd, input logic [NC-1:0] r, input logic [NC-1:0] e,
                     input logic [NC-1:0] exp_bits, input int exp_cnt, input logic exp_sat,
                     input logic [NC-1:0] t);
    finish = 1'b1; update = with_upd; res = r; en = e;
    exp_q.push_back(exp_bits);
    cyc();
    finish = 1'b0; update = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    tie = t;
    cyc();
    tie = ~t;
    check("hold_valid", out_valid, 1);
    check("hold_count", update_count, exp_cnt);
    check("hold_sat", sat_flag, exp_sat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("hs_valid", out_valid, 0);
    check("hs_count", update_count, 0);
    check("hs_sat", sat_flag, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sel", sel_bits, 0);
    check("rst_count", update_count, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_out_bits", out_bits, 0);
    #5 rst_n = 1'b1;

    // All lanes +1 three times.
    upd(4'b0000, 4'b0000);
    check("sel_all_pos", sel_bits, 8'b01_01_01_01);
    upd(4'b0000, 4'b0000);
    upd(4'b0000, 4'b0000);
    check("count_3", update_count, 3);
    fin(1'b0, 4'b0000, 4'b0000, 4'b0000, 3, 1'b0, 4'b0000);
    handshake();
    check("sel_idle_zero", sel_bits, 0);

    // Mixed lanes: -2, +1, 0 (tie), +2; second update rides with finish.
    upd(4'b1010, 4'b0100);
    check("sel_mixed", sel_bits, 8'b11_00_11_01);
    fin(1'b1, 4'b1000, 4'b0000, 4'b1010, 2, 1'b0, 4'b0010);
    handshake();

    // Lane0 driven negative five times clamps at -3.
    for (int i = 0; i < 5; i++) upd(4'b0001, 4'b1110);
    check("sat_lane0", sat_flag, 1);
    fin(1'b0, 4'b0000, 4'b0000, 4'b0001, 5, 1'b1, 4'b0000);
    handshake();

    // HOLD backpressure: updates and finishes are ignored.
    upd(4'b1111, 4'b0000);
    fin(1'b0, 4'b0000, 4'b0000, 4'b1111, 1, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      update = i[0]; finish = i[1]; res = 4'b0000; en = 4'b0000;
      cyc();
      check("bp_out_bits", out_bits, 4'b1111);
      check("bp_in_ready", in_ready, 0);
      check("bp_count", update_count, 1);
    end
    update = 1'b0; finish = 1'b0;
    handshake();
    // Empty bundle proves accumulators were zeroed: result is all tie bits.
    fin(1'b0, 4'b0000, 4'b0000, 4'b0101, 0, 1'b0, 4'b0101);
    handshake();

    // clear in DRAIN together with an update aborts the bundle.
    upd(4'b1111, 4'b0000);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    clear = 1'b1; update = 1'b1; res = 4'b1111; en = 4'b0000;
    cyc();
    clear = 1'b0; update = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_count", update_count, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_sel", sel_bits, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("clr_valid_stays_low", out_valid, 0);
    end
    upd(4'b0000, 4'b1110);
    fin(1'b0, 4'b0000, 4'b0000, 4'b0000, 1, 1'b0, 4'b0000);
    handshake();

    // Update counter saturates at all-ones; accumulators clamp at +3.
    update = 1'b1; res = 4'b0000; en = 4'b0000;
    for (int i = 0; i < 17; i++) cyc();
    update = 1'b0;
    check("count_sat", update_count, 15);
    fin(1'b0, 4'b0000, 4'b0000, 4'b0000, 15, 1'b1, 4'b0000);
    handshake();

    // Asynchronous reset in HOLD, away from the clock edge.
    upd(4'b0000, 4'b0000);
    fin(1'b0, 4'b0000, 4'b0000, 4'b0000, 1, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_sel", sel_bits, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_count", update_count, 0);
    exp_q.delete();
    #7 rst_n = 1'b1;
    upd(4'b1010, 4'b0100);
    fin(1'b1, 4'b1000, 4'b0000, 4'b1010, 2, 1'b0, 4'b0010);
    handshake();

    repeat (3) cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
